// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier between two valid/ready clients.
// Optional BUSY watchdog compiled in with `define MULT_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module mult_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_product,
    output logic        rsp0_overflow,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_product,
    output logic        rsp1_overflow,
    output logic        rsp1_err,
    output logic        mult_begin,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    input  logic [63:0] product,
    input  logic        mult_end,
    input  logic        overflow,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on the rising edge where valid & ready are both high.
    // reqN_ready depends combinationally on the valids; rspN_valid is registered and
    // holds with its payload until the consumer raises rspN_ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   ptr;       // 0 favours req0 when both are valid
    logic   gnt_id;    // requester owning the operation in flight
    logic   grant;
    logic   accept;
    logic   done;
    logic   timed_out;
    logic   rsp_hs;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("mult_arbiter: TIMEOUT must be >= 2");
    end

    assign grant      = (req0_valid & req1_valid) ? ptr : req1_valid;
    assign accept     = (state == IDLE) & (req0_valid | req1_valid);
    assign req0_ready = accept & ~grant;
    assign req1_ready = accept & grant;
    assign rsp_hs     = gnt_id ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);
    assign done       = (state == BUSY) & (mult_end | timed_out);
    assign state_dbg  = state;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] busy_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_cnt <= '0;
        end else if (accept) begin
            busy_cnt <= '0;
        end else if (state == BUSY && !mult_end) begin
            busy_cnt <= busy_cnt + CW'(1);
        end
    end

    // mult_end on the expiry edge takes priority over the abort
    assign timed_out = (state == BUSY) & ~mult_end & (busy_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp0_err <= 1'b0;
            rsp1_err <= 1'b0;
        end else if (done) begin
            if (gnt_id) rsp1_err <= ~mult_end;
            else        rsp0_err <= ~mult_end;
        end
    end
`else
    assign timed_out = 1'b0;
    assign rsp0_err  = 1'b0;
    assign rsp1_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (done)   state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr           <= 1'b0;
            gnt_id        <= 1'b0;
            mult_begin    <= 1'b0;
            mult_op1      <= '0;
            mult_op2      <= '0;
            rsp0_valid    <= 1'b0;
            rsp0_product  <= '0;
            rsp0_overflow <= 1'b0;
            rsp1_valid    <= 1'b0;
            rsp1_product  <= '0;
            rsp1_overflow <= 1'b0;
        end else begin
            if (accept) begin
                mult_op1   <= grant ? req1_op1 : req0_op1;
                mult_op2   <= grant ? req1_op2 : req0_op2;
                gnt_id     <= grant;
                ptr        <= ~grant;
                mult_begin <= 1'b1;
            end
            if (done) begin
                mult_begin <= 1'b0;
                // An aborted operation returns a zero payload
                if (gnt_id) begin
                    rsp1_valid    <= 1'b1;
                    rsp1_product  <= mult_end ? product : 64'd0;
                    rsp1_overflow <= mult_end & overflow;
                end else begin
                    rsp0_valid    <= 1'b1;
                    rsp0_product  <= mult_end ? product : 64'd0;
                    rsp0_overflow <= mult_end & overflow;
                end
            end
            if (state == RESP && rsp_hs) begin
                if (gnt_id) rsp1_valid <= 1'b0;
                else        rsp0_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: iterative multiplier stub, vector table, scoreboard and corner sequences.
module tb_mult_arbiter;
    typedef logic [71:0] cv_t;
    typedef struct {
        bit          who;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vec_t;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [63:0] rsp0_product, rsp1_product;
    logic        rsp0_overflow, rsp1_overflow, rsp0_err, rsp1_err;
    logic        mult_begin;
    logic [31:0] mult_op1, mult_op2;
    logic [63:0] product;
    logic        mult_end, overflow;
    logic [1:0]  state_dbg;

    int          lat = 8;
    bit          hang = 1'b0;
    int          stub_cnt;
    int          checks = 0, errors = 0;
    logic [65:0] exp0_q[$], exp1_q[$];
    bit          grant_q[$];
    bit          rsp0_seen = 1'b0, rsp1_seen = 1'b0;
    int          low_run = 0;
    bit          seen_high = 1'b0;
    vec_t        vecs[8];

    mult_arbiter #(.TIMEOUT(64)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_product(rsp0_product),
        .rsp0_overflow(rsp0_overflow), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_product(rsp1_product),
        .rsp1_overflow(rsp1_overflow), .rsp1_err(rsp1_err),
        .mult_begin(mult_begin), .mult_op1(mult_op1), .mult_op2(mult_op2),
        .product(product), .mult_end(mult_end), .overflow(overflow), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic ovf_fn(input logic [31:0] a, input logic [31:0] b);
        return a[31] ^ b[0];
    endfunction

    function automatic logic [65:0] expect_of(input logic [31:0] a, input logic [31:0] b);
        if (hang) return {1'b1, 1'b0, 64'd0};
        return {1'b0, ovf_fn(a, b), 64'(a) * 64'(b)};
    endfunction

    task automatic check(input string name, input cv_t act, input cv_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Multiplier stub: result after lat+1 cycles of mult_begin, held until mult_begin drops
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stub_cnt <= 0; mult_end <= 1'b0; product <= '0; overflow <= 1'b0;
        end else if (!mult_begin) begin
            stub_cnt <= 0; mult_end <= 1'b0;
        end else if (!hang && !mult_end) begin
            if (stub_cnt >= lat) begin
                mult_end <= 1'b1;
                product  <= 64'(mult_op1) * 64'(mult_op2);
                overflow <= ovf_fn(mult_op1, mult_op2);
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!resetn) begin
            seen_high = 1'b0;
            low_run = 0;
        end else begin
            if (req0_valid && req0_ready) begin
                grant_q.push_back(1'b0);
                exp0_q.push_back(expect_of(req0_op1, req0_op2));
            end
            if (req1_valid && req1_ready) begin
                grant_q.push_back(1'b1);
                exp1_q.push_back(expect_of(req1_op1, req1_op2));
            end
            if (rsp0_valid) rsp0_seen = 1'b1;
            if (rsp1_valid) rsp1_seen = 1'b1;
            if (rsp0_valid && rsp0_ready) begin
                if (exp0_q.size() == 0) check("rsp0_unexpected", 1, 0);
                else check("rsp0_sb", cv_t'({rsp0_err, rsp0_overflow, rsp0_product}), cv_t'(exp0_q.pop_front()));
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp1_q.size() == 0) check("rsp1_unexpected", 1, 0);
                else check("rsp1_sb", cv_t'({rsp1_err, rsp1_overflow, rsp1_product}), cv_t'(exp1_q.pop_front()));
            end
            if (mult_begin) begin
                if (seen_high && low_run > 0) check("issue_gap_ge2", cv_t'(low_run >= 2), 1);
                seen_high = 1'b1;
                low_run = 0;
            end else begin
                low_run++;
            end
        end
    end

    task automatic reset_dut();
        resetn = 1'b0;
        exp0_q.delete(); exp1_q.delete(); grant_q.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic send(input bit who, input logic [31:0] a, input logic [31:0] b);
        bit got = 1'b0;
        if (who) begin req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; end
        else     begin req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (who ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
                got = 1'b1;
                break;
            end
        end
        check(who ? "req1_accept" : "req0_accept", cv_t'(got), 1);
        @(posedge clk);
        #1;
        if (who) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit who, output logic [63:0] p, output logic e);
        bit got = 1'b0;
        p = '0;
        e = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (who ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready)) begin
                got = 1'b1;
                p = who ? rsp1_product : rsp0_product;
                e = who ? rsp1_err : rsp0_err;
                break;
            end
        end
        check("rsp_arrived", cv_t'(got), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic contend(input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1);
        bit acc0, acc1;
        req0_valid = 1'b1; req0_op1 = a0; req0_op2 = b0;
        req1_valid = 1'b1; req1_op1 = a1; req1_op2 = b1;
        for (int k = 0; k < 600; k++) begin
            if (!req0_valid && !req1_valid) break;
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
        end
        check("contend_done", cv_t'(req0_valid | req1_valid), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (exp0_q.size() == 0 && exp1_q.size() == 0 && !rsp0_valid && !rsp1_valid
                && state_dbg == 2'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", cv_t'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p, p_hold;
        logic        e;
        logic [31:0] ra, rb;
        int          n, bad, early;

        vecs[0] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
        vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[2] = '{1'b0, 32'h00000000, 32'hDEADBEEF, 64'h0000000000000000};
        vecs[3] = '{1'b1, 32'h00000001, 32'hCAFEBABE, 64'h00000000CAFEBABE};
        vecs[4] = '{1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000};
        vecs[5] = '{1'b1, 32'h00000003, 32'h00000005, 64'h000000000000000F};
        for (int i = 6; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            vecs[i] = '{(i == 7), ra, rb, 64'(ra) * 64'(rb)};
        end

        // Reset state
        @(negedge clk);
        check("rst_mult_begin", cv_t'(mult_begin), 0);
        check("rst_mult_ops", cv_t'({mult_op1, mult_op2}), 0);
        check("rst_ready", cv_t'({req0_ready, req1_ready}), 0);
        check("rst_rsp0", cv_t'({rsp0_valid, rsp0_product, rsp0_overflow, rsp0_err}), 0);
        check("rst_rsp1", cv_t'({rsp1_valid, rsp1_product, rsp1_overflow, rsp1_err}), 0);
        check("rst_state", cv_t'(state_dbg), 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Table-driven single requests
        for (int i = 0; i < 8; i++) begin
            rsp0_seen = 1'b0;
            rsp1_seen = 1'b0;
            send(vecs[i].who, vecs[i].a, vecs[i].b);
            wait_rsp(vecs[i].who, p, e);
            check($sformatf("vec%0d_product", i), cv_t'(p), cv_t'(vecs[i].prod));
            check($sformatf("vec%0d_err", i), cv_t'(e), 0);
            check($sformatf("vec%0d_begin_low", i), cv_t'(mult_begin), 0);
            check($sformatf("vec%0d_other_rsp_quiet", i),
                  cv_t'(vecs[i].who ? rsp0_seen : rsp1_seen), 0);
        end

        // Contention right after reset: req0 first
        reset_dut();
        contend(32'd3, 32'd5, 32'd7, 32'd9);
        wait_drain();
        check("contend_grants", cv_t'(grant_q.size()), 2);
        if (grant_q.size() == 2) begin
            check("contend_first", cv_t'(grant_q[0]), 0);
            check("contend_second", cv_t'(grant_q[1]), 1);
        end

        // Round-robin with both requesters continuously valid
        grant_q.delete();
        req0_valid = 1'b1; req0_op1 = $urandom; req0_op2 = $urandom;
        req1_valid = 1'b1; req1_op1 = $urandom; req1_op2 = $urandom;
        n = 0;
        for (int k = 0; k < 800 && n < 4; k++) begin
            bit acc0, acc1;
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (acc0) begin n++; req0_op1 = $urandom; req0_op2 = $urandom; end
            if (acc1) begin n++; req1_op1 = $urandom; req1_op2 = $urandom; end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();
        check("rr_count", cv_t'(grant_q.size()), 4);
        if (grant_q.size() == 4)
            for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), cv_t'(grant_q[i]), cv_t'(i % 2));

        // Response backpressure on requester 1
        grant_q.delete();
        rsp1_ready = 1'b0;
        send(1'b1, 32'h00001234, 32'h00005678);
        req0_valid = 1'b1; req0_op1 = 32'd21; req0_op2 = 32'd2;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rsp1_valid) begin n = 1; break; end
        end
        check("bp_rsp_valid", cv_t'(n), 1);
        p_hold = rsp1_product;
        check("bp_product", cv_t'(p_hold), cv_t'(64'h0000000006260060));
        bad = 0;
        early = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!(rsp1_valid && rsp1_product == p_hold)) bad++;
            if (req0_ready) early++;
        end
        check("bp_stable", cv_t'(bad), 0);
        check("bp_req0_held", cv_t'(early), 0);
        rsp1_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req0_ready && rsp1_valid) early++;
            if (req0_valid && req0_ready) begin n = 1; break; end
        end
        check("bp_req0_after", cv_t'({n[0], early[7:0]}), cv_t'({1'b1, 8'd0}));
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_drain();
        check("bp_order", cv_t'({grant_q.size() == 2, grant_q.size() == 2 ? {grant_q[0], grant_q[1]} : 2'b00}),
              cv_t'({1'b1, 2'b10}));

        // Reset in the middle of a long operation owned by req0
        lat = 32;
        send(1'b0, 32'd100, 32'd200);
        repeat (15) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst_begin_low", cv_t'(mult_begin), 0);
        check("midrst_state", cv_t'(state_dbg), 0);
        exp0_q.delete(); exp1_q.delete(); grant_q.delete();
        rsp0_seen = 1'b0;
        rsp1_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        lat = 8;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_rsp", cv_t'({rsp0_seen, rsp1_seen}), 0);
        contend(32'd11, 32'd13, 32'd17, 32'd19);
        wait_drain();
        check("midrst_grant_req0", cv_t'(grant_q.size() > 0 ? grant_q[0] : 1'b1), 0);

        // Multiplier that never finishes
        hang = 1'b1;
        rsp0_seen = 1'b0;
        send(1'b0, 32'd11, 32'd22);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n++;
            if (rsp0_valid) break;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        // the n-th falling edge after the accept follows the (n-1)-th rising edge
        check("timeout_cycles", cv_t'(n - 1), 64);
        check("timeout_err", cv_t'(rsp0_err), 1);
        check("timeout_payload", cv_t'({rsp0_overflow, rsp0_product}), 0);
        @(posedge clk);
        #1 hang = 1'b0;
        wait_drain();
`else
        check("hang_no_rsp", cv_t'({rsp0_seen, rsp0_err}), 0);
        check("hang_begin_held", cv_t'(mult_begin), 1);
        check("hang_state_busy", cv_t'(state_dbg), 1);
        @(posedge clk);
        #1 hang = 1'b0;
        reset_dut();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
